int_ctrl: RTL

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl_pkg.sv | 40 ++++
 rtl/int_prio_enc.sv | 17 +
 rtl/int_ctrl.sv | 95 +++++++++
 3 files changed

// File: rtl/int_ctrl_pkg.sv
// rtl/int_ctrl_pkg.sv - shared 8051 defines: opcodes, interrupt sources, vectors, states
package int_ctrl_pkg;

  // Opcode constants used around the interrupt path
  localparam logic [7:0] OP_LCALL = 8'h12;
  localparam logic [7:0] OP_RETI  = 8'h32;

  // Interrupt source indices, in fixed priority order within a level
  localparam logic [2:0] SRC_IE0 = 3'd0;
  localparam logic [2:0] SRC_TF0 = 3'd1;
  localparam logic [2:0] SRC_IE1 = 3'd2;
  localparam logic [2:0] SRC_TF1 = 3'd3;
  localparam logic [2:0] SRC_SER = 3'd4;

  // Vector spacing between consecutive sources
  localparam int VEC_SHIFT = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_VEC  = 2'd1,
    ST_HOLD = 2'd2
  } int_state_t;

  // Vector low byte for a source: base + 8*idx
  function automatic logic [7:0] vec_of(input logic [7:0] base, input logic [2:0] idx);
    return base + (8'(idx) << VEC_SHIFT);
  endfunction

  // Flag-clear mask: timers always, externals only when edge-triggered, serial never
  function automatic logic [3:0] clr_of(input logic [2:0] idx, input logic [1:0] it);
    case (idx)
      SRC_IE0: return {3'b000, it[0]};
      SRC_TF0: return 4'b0010;
      SRC_IE1: return {1'b0, it[1], 2'b00};
      SRC_TF1: return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// rtl/int_prio_enc.sv - 5-bit fixed-priority encoder, bit 0 highest
module int_prio_enc (
  input  logic [4:0] req,
  output logic       valid,
  output logic [2:0] idx
);

  // Scan from lowest priority upward so the lowest set index wins
  always_comb begin
    valid = |req;
    idx   = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - 8051-style two-level interrupt controller
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter logic [7:0] VEC_BASE = 8'h03
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rd,
  input  logic [4:0] src,
  input  logic [7:0] ie,
  input  logic [4:0] ip,
  input  logic [1:0] it,
  input  logic       reti,
  output logic       int_req,
  output logic [7:0] int_v,
  output logic [3:0] clr,
  output logic [1:0] isr_act
);

  int_state_t state;
  logic [4:0] pend;
  logic [4:0] hi_req;
  logic [4:0] lo_req;
  logic       hi_valid;
  logic       lo_valid;
  logic [2:0] hi_idx;
  logic [2:0] lo_idx;
  logic       sel_valid;
  logic [2:0] sel_idx;
  logic [1:0] act_post;
  logic       ie_unused;

  assign ie_unused = ^ie[6:5];

  // Eligibility per level, gated by the in-service state seen this cycle
  always_comb begin
    pend   = src & ie[4:0] & {5{ie[7]}};
    hi_req = isr_act[1] ? 5'b00000 : (pend & ip);
    lo_req = (isr_act == 2'b00) ? (pend & ~ip) : 5'b00000;
  end

  int_prio_enc u_enc_hi (
    .req   (hi_req),
    .valid (hi_valid),
    .idx   (hi_idx)
  );

  int_prio_enc u_enc_lo (
    .req   (lo_req),
    .valid (lo_valid),
    .idx   (lo_idx)
  );

  // High level wins over low; reti retires the highest active level first
  always_comb begin
    sel_valid = hi_valid | lo_valid;
    sel_idx   = hi_valid ? hi_idx : lo_idx;
    act_post  = isr_act;
    if (reti) begin
      if (isr_act[1]) act_post[1] = 1'b0;
      else            act_post[0] = 1'b0;
    end
  end

  // Request FSM: IDLE -> VEC (int pulse) -> HOLD (LCALL in flight) -> IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      int_req <= 1'b0;
      int_v   <= 8'h00;
      clr     <= 4'b0000;
      isr_act <= 2'b00;
    end else begin
      int_req <= 1'b0;
      clr     <= 4'b0000;
      isr_act <= act_post;
      case (state)
        ST_IDLE: begin
          if (rd && sel_valid) begin
            state   <= ST_VEC;
            int_req <= 1'b1;
            int_v   <= vec_of(VEC_BASE, sel_idx);
            clr     <= clr_of(sel_idx, it);
            if (hi_valid) isr_act <= act_post | 2'b10;
            else          isr_act <= act_post | 2'b01;
          end
        end
        ST_VEC:  state <= ST_HOLD;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
